// File: rtl/instr_register_pkg.sv
// Shared types and sizing for the instruction register and its FIFO controller.
package instr_register_pkg;

  localparam int DEPTH   = 32;
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int COUNT_W = ADDR_W + 1;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic [ADDR_W-1:0]  address_t;
  typedef logic [COUNT_W-1:0] count_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  // Pointers wrap naturally from DEPTH-1 to 0 because DEPTH is a power of two.
  function automatic address_t ptr_inc(input address_t p);
    return p + address_t'(1);
  endfunction

endpackage

// File: rtl/instr_reg_ctrl_if.sv
// Bundle of requester, instruction-register and issue signals around the controller.
interface instr_reg_ctrl_if;
  import instr_register_pkg::*;

  // Requesters
  logic         req0_valid;
  opcode_t      req0_opcode;
  operand_t     req0_op_a;
  operand_t     req0_op_b;
  logic         req0_ready;
  logic         req1_valid;
  opcode_t      req1_opcode;
  operand_t     req1_op_a;
  operand_t     req1_op_b;
  logic         req1_ready;
  logic         flush;

  // Instruction register write and read ports
  logic         ir_load_en;
  address_t     ir_write_pointer;
  opcode_t      ir_opcode;
  operand_t     ir_operand_a;
  operand_t     ir_operand_b;
  address_t     ir_read_pointer;
  instruction_t ir_instruction_word;

  // Issue side and status
  logic         issue_valid;
  logic         issue_ready;
  instruction_t issue_word;
  count_t       count;
  logic         full;
  logic         empty;

  // Controller side
  modport slave (
    input  req0_valid, req0_opcode, req0_op_a, req0_op_b,
    input  req1_valid, req1_opcode, req1_op_a, req1_op_b,
    input  flush, ir_instruction_word, issue_ready,
    output req0_ready, req1_ready,
    output ir_load_en, ir_write_pointer, ir_opcode, ir_operand_a, ir_operand_b,
    output ir_read_pointer, issue_valid, issue_word, count, full, empty
  );

  // Environment side: requesters, instruction register and consumer
  modport master (
    output req0_valid, req0_opcode, req0_op_a, req0_op_b,
    output req1_valid, req1_opcode, req1_op_a, req1_op_b,
    output flush, ir_instruction_word, issue_ready,
    input  req0_ready, req1_ready,
    input  ir_load_en, ir_write_pointer, ir_opcode, ir_operand_a, ir_operand_b,
    input  ir_read_pointer, issue_valid, issue_word, count, full, empty
  );

endinterface

// File: rtl/instr_reg_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, prio selects the preferred side.
module rr_arb2 (
  input  logic       i_valid0,
  input  logic       i_valid1,
  input  logic       i_prio,
  input  logic       i_enable,
  output logic [1:0] o_grant
);

  // Grant the preferred requester on contention, otherwise whichever is valid.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    o_grant = 2'b00;
    if (i_enable) begin
      if (i_valid0 && i_valid1) begin
        o_grant = i_prio ? 2'b10 : 2'b01;
      end else begin
        o_grant = {i_valid1, i_valid0};
      end
    end
  end

endmodule

// File: rtl/instr_reg_ctrl.sv
// FIFO controller that runs a 32-entry instruction register for two requesters.
module instr_reg_ctrl
  import instr_register_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  instr_reg_ctrl_if.slave  bus
);

  address_t   r_wr_ptr;
  address_t   r_rd_ptr;
  count_t     r_count;
  logic       r_prio;

  logic       w_full;
  logic       w_empty;
  logic       w_arb_en;
  logic [1:0] w_grant;
  logic       w_write;
  logic       w_pop;

  // Status comes from the registered count, so a same-cycle pop never frees a slot early.
  assign w_full   = (r_count == count_t'(DEPTH));
  assign w_empty  = (r_count == '0);
  // Reset is included so nothing is granted while the block is held in reset.
  assign w_arb_en = reset_n & ~w_full & ~bus.flush;
  assign w_write  = |w_grant;
  assign w_pop    = ~w_empty & bus.issue_ready & ~bus.flush;

  rr_arb2 u_arb (
    .i_valid0 (bus.req0_valid),
    .i_valid1 (bus.req1_valid),
    .i_prio   (r_prio),
    .i_enable (w_arb_en),
    .o_grant  (w_grant)
  );

  assign bus.req0_ready       = w_grant[0];
  assign bus.req1_ready       = w_grant[1];
  assign bus.ir_write_pointer = r_wr_ptr;
  assign bus.ir_read_pointer  = r_rd_ptr;
  assign bus.issue_valid      = ~w_empty;
  assign bus.issue_word       = bus.ir_instruction_word;
  assign bus.count            = r_count;
  assign bus.full             = w_full;
  assign bus.empty            = w_empty;

  // Steer the granted requester's fields onto the write port; zero when idle.
  always_comb begin
    bus.ir_load_en   = 1'b0;
    bus.ir_opcode    = ZERO;
    bus.ir_operand_a = '0;
    bus.ir_operand_b = '0;
    if (w_grant[0]) begin
      bus.ir_load_en   = 1'b1;
      bus.ir_opcode    = bus.req0_opcode;
      bus.ir_operand_a = bus.req0_op_a;
      bus.ir_operand_b = bus.req0_op_b;
    end else if (w_grant[1]) begin
      bus.ir_load_en   = 1'b1;
      bus.ir_opcode    = bus.req1_opcode;
      bus.ir_operand_a = bus.req1_op_a;
      bus.ir_operand_b = bus.req1_op_b;
    end
  end

  // Pointer, occupancy and priority state; flush outranks writes and pops.
  // The instruction register itself is never cleared: resetting the pointers makes old entries unreachable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_prio   <= 1'b0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_prio   <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
      if (w_write) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)   r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_write && !w_pop) begin
        r_count <= r_count + count_t'(1);
      end else if (w_pop && !w_write) begin
        r_count <= r_count - count_t'(1);
      end
      // After a grant the other requester becomes preferred.
      if (w_write) r_prio <= w_grant[0];
    end
  end

endmodule

// File: tb/tb_instr_reg_ctrl.sv
// Directed bench for instr_reg_ctrl with a behavioural instruction register.
module tb_instr_reg_ctrl;
  import instr_register_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  instr_reg_ctrl_if bus ();

  instr_reg_ctrl u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Behavioural instruction register: synchronous write, combinational read.
  instruction_t mem [DEPTH];
  always @(posedge clk) begin
    if (bus.ir_load_en)
      mem[bus.ir_write_pointer] <= '{opc: bus.ir_opcode, op_a: bus.ir_operand_a, op_b: bus.ir_operand_b};
  end
  assign bus.ir_instruction_word = mem[bus.ir_read_pointer];

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic instruction_t mk(input opcode_t o, input int a, input int b);
    instruction_t w;
    w.opc  = o;
    w.op_a = operand_t'(a);
    w.op_b = operand_t'(b);
    return w;
  endfunction

  task automatic idle();
    bus.req0_valid  = 1'b0;
    bus.req0_opcode = ZERO;
    bus.req0_op_a   = '0;
    bus.req0_op_b   = '0;
    bus.req1_valid  = 1'b0;
    bus.req1_opcode = ZERO;
    bus.req1_op_a   = '0;
    bus.req1_op_b   = '0;
    bus.flush       = 1'b0;
    bus.issue_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Write n entries through requester 0, one per cycle; op_a = base + i.
  task automatic write_n(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.req0_valid  = 1'b1;
      bus.req0_opcode = MULT;
      bus.req0_op_a   = operand_t'(base + i);
      bus.req0_op_b   = '0;
      #1;
      check("wr_ready0", bus.req0_ready, 1);
      @(posedge clk);
    end
  endtask

  instruction_t exp_q[$];
  instruction_t exp_w;

  initial begin
    // Reset state, with a requester already valid
    idle();
    bus.req0_valid = 1'b1;
    reset_n = 1'b0;
    #3;
    check("rst_ready0", bus.req0_ready, 0);
    check("rst_load_en", bus.ir_load_en, 0);
    check("rst_issue_valid", bus.issue_valid, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_count", bus.count, 0);
    check("rst_wptr", bus.ir_write_pointer, 0);
    check("rst_rptr", bus.ir_read_pointer, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single write ADD 5,3 then visible on issue_word next cycle
    bus.req0_opcode = ADD;
    bus.req0_op_a   = 5;
    bus.req0_op_b   = 3;
    #1;
    check("w1_load_en", bus.ir_load_en, 1);
    check("w1_wptr", bus.ir_write_pointer, 0);
    check("w1_ready0", bus.req0_ready, 1);
    check("w1_opcode", bus.ir_opcode, ADD);
    check("w1_op_a", bus.ir_operand_a, 5);
    check("w1_op_b", bus.ir_operand_b, 3);
    @(negedge clk);
    idle();
    #1;
    check("w1_issue_valid", bus.issue_valid, 1);
    check("w1_issue_word", bus.issue_word, mk(ADD, 5, 3));
    check("w1_count", bus.count, 1);
    check("idle_load_en", bus.ir_load_en, 0);
    check("idle_op_a", bus.ir_operand_a, 0);
    check("idle_opcode", bus.ir_opcode, ZERO);

    // Both valid: grants alternate 0,1,0,1
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.req0_valid = 1'b1; bus.req0_opcode = ADD; bus.req0_op_a = 1; bus.req0_op_b = 1;
      bus.req1_valid = 1'b1; bus.req1_opcode = SUB; bus.req1_op_a = 2; bus.req1_op_b = 2;
      #1;
      check("rr_ready0", bus.req0_ready, (i % 2 == 0));
      check("rr_ready1", bus.req1_ready, (i % 2 == 1));
      check("rr_wptr", bus.ir_write_pointer, address_t'(i));
      check("rr_opcode", bus.ir_opcode, (i % 2 == 0) ? ADD : SUB);
      @(posedge clk);
    end
    @(negedge clk);
    idle();
    #1;
    check("rr_count", bus.count, 4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.issue_ready = 1'b1;
      #1;
      check("rr_pop_word", bus.issue_word, (i % 2 == 0) ? mk(ADD, 1, 1) : mk(SUB, 2, 2));
      @(posedge clk);
    end
    @(negedge clk);
    idle();
    #1;
    check("rr_drained", bus.empty, 1);

    // Fill to 32, then a pop with valid high does not grant until the next cycle
    do_reset();
    write_n(32, 0);
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_opcode = MULT; bus.req0_op_a = 99; bus.req0_op_b = 0;
    bus.req1_valid = 1'b1; bus.req1_opcode = DIV;  bus.req1_op_a = 77; bus.req1_op_b = 0;
    #1;
    check("full_flag", bus.full, 1);
    check("full_count", bus.count, 32);
    check("full_ready0", bus.req0_ready, 0);
    check("full_ready1", bus.req1_ready, 0);
    @(negedge clk);
    bus.issue_ready = 1'b1;
    #1;
    check("fullpop_ready0", bus.req0_ready, 0);
    check("fullpop_ready1", bus.req1_ready, 0);
    check("fullpop_load_en", bus.ir_load_en, 0);
    check("fullpop_word", bus.issue_word, mk(MULT, 0, 0));
    @(negedge clk);
    bus.issue_ready = 1'b0;
    #1;
    check("after_pop_count", bus.count, 31);
    check("after_pop_ready1", bus.req1_ready, 1);
    check("after_pop_ready0", bus.req0_ready, 0);
    @(negedge clk);
    idle();
    #1;
    check("refill_count", bus.count, 32);
    check("refill_full", bus.full, 1);

    // 40 writes and 40 pops interleaved: pointers wrap, order preserved
    do_reset();
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk);
      bus.req0_valid  = (i < 40);
      bus.req0_opcode = PASSA;
      bus.req0_op_a   = operand_t'(100 + i);
      bus.req0_op_b   = operand_t'(i);
      bus.issue_ready = 1'b1;
      #1;
      if (i < 40) begin
        check("wrap_wptr", bus.ir_write_pointer, address_t'(i));
        check("wrap_ready0", bus.req0_ready, 1);
        exp_q.push_back(mk(PASSA, 100 + i, i));
      end
      if (i == 0) begin
        check("wrap_first_empty", bus.issue_valid, 0);
      end else begin
        exp_w = exp_q.pop_front();
        check("wrap_rptr", bus.ir_read_pointer, address_t'(i - 1));
        check("wrap_issue_valid", bus.issue_valid, 1);
        check("wrap_word", bus.issue_word, exp_w);
      end
      @(posedge clk);
    end
    @(negedge clk);
    idle();
    #1;
    check("wrap_end_empty", bus.empty, 1);
    check("wrap_end_count", bus.count, 0);

    // Write+pop at count 7, then flush
    do_reset();
    write_n(7, 200);
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_opcode = SUB; bus.req0_op_a = 7; bus.req0_op_b = 7;
    bus.issue_ready = 1'b1;
    #1;
    check("wp_ready0", bus.req0_ready, 1);
    check("wp_word", bus.issue_word, mk(MULT, 200, 0));
    @(negedge clk);
    idle();
    #1;
    check("wp_count", bus.count, 7);
    @(negedge clk);
    bus.flush = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_opcode = SUB; bus.req0_op_a = 8; bus.req0_op_b = 8;
    bus.issue_ready = 1'b1;
    #1;
    check("flush_ready0", bus.req0_ready, 0);
    check("flush_load_en", bus.ir_load_en, 0);
    @(negedge clk);
    idle();
    #1;
    check("flush_count", bus.count, 0);
    check("flush_empty", bus.empty, 1);
    check("flush_issue_valid", bus.issue_valid, 0);
    check("flush_wptr", bus.ir_write_pointer, 0);
    check("flush_rptr", bus.ir_read_pointer, 0);
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    check("flush_prio", bus.req0_ready, 1);
    @(negedge clk);
    idle();

    // Asynchronous reset mid-stream at count 10
    do_reset();
    write_n(10, 300);
    @(negedge clk);
    idle();
    #1;
    check("pre_rst_count", bus.count, 10);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_count", bus.count, 0);
    check("async_issue_valid", bus.issue_valid, 0);
    check("async_empty", bus.empty, 1);
    check("async_wptr", bus.ir_write_pointer, 0);
    check("async_rptr", bus.ir_read_pointer, 0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
